// File: rtl/joy_serial_reader_if.sv
// Pin-side and core-side signals of the serial joystick reader, bundled so the
// reader (master) and the surrounding logic (slave) see consistent directions.
interface joy_serial_reader_if #(
    parameter int PLAYERS = 2,
    parameter int BITS    = 16
);
    logic                      enable;
    logic                      JOY_DATA;
    logic                      JOY_CLK;
    logic                      JOY_LOAD;
    logic [PLAYERS*BITS-1:0]   joystick;
    logic [PLAYERS-1:0]        present;
    logic                      valid;

    modport master (
        input  enable,
        input  JOY_DATA,
        output JOY_CLK,
        output JOY_LOAD,
        output joystick,
        output present,
        output valid
    );

    modport slave (
        output enable,
        output JOY_DATA,
        input  JOY_CLK,
        input  JOY_LOAD,
        input  joystick,
        input  present,
        input  valid
    );
endinterface

// File: rtl/joy_serial_reader.sv
// Serial-shift joystick reader for 74HC165-style chains: drives load/clock strobes,
// shifts in PLAYERS*BITS bits and publishes one decoded, coherent word per frame.
module joy_serial_reader #(
    parameter int PLAYERS    = 2,
    parameter int BITS       = 16,
    parameter int CLK_DIV    = 250,
    parameter int LOAD_TICKS = 2,
    parameter int INVERT     = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    joy_serial_reader_if.master  bus
);
    localparam int N  = PLAYERS * BITS;
    localparam int KW = $clog2(N);
    localparam int CW = $clog2(CLK_DIV);
    localparam int LW = $clog2(LOAD_TICKS + 1);

    localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
    localparam logic [KW-1:0] K_LAST    = KW'(N - 1);
    localparam logic [LW-1:0] LOAD_LAST = LW'(LOAD_TICKS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_COMMIT   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [KW-1:0]      k_q, k_d;
    logic [LW-1:0]      load_cnt_q, load_cnt_d;
    logic [N-1:0]       raw_q, raw_d;
    logic               sd1_q, sd1_d;
    logic               sd_q, sd_d;
    logic               joy_clk_q, joy_clk_d;
    logic               joy_load_q, joy_load_d;
    logic [N-1:0]       joystick_q, joystick_d;
    logic [PLAYERS-1:0] present_q, present_d;
    logic               valid_q, valid_d;
    logic               tick_s;
    logic [N+PLAYERS-1:0] decoded_s;

    // Per-pad polarity fix-up and presence test; an all-pressed pad is treated as absent.
    function automatic logic [N+PLAYERS-1:0] decode(input logic [N-1:0] raw);
        logic [BITS-1:0]    w;
        logic [BITS-1:0]    d;
        logic [PLAYERS-1:0] pres;
        logic [N-1:0]       joy;
        pres = {PLAYERS{1'b0}};
        joy  = {N{1'b0}};
        for (int p = 0; p < PLAYERS; p++) begin
            w       = raw[p*BITS +: BITS];
            d       = (INVERT != 0) ? ~w : w;
            pres[p] = ~(&d);
            joy[p*BITS +: BITS] = pres[p] ? d : {BITS{1'b0}};
        end
        return {pres, joy};
    endfunction

    assign tick_s    = (cnt_q == TICK_LAST);
    assign decoded_s = decode(raw_q);

    // Next-state logic: tick divider, synchroniser, frame sequencer and strobe levels.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        load_cnt_d = load_cnt_q;
        raw_d      = raw_q;
        joystick_d = joystick_q;
        present_d  = present_q;
        valid_d    = 1'b0;
        cnt_d      = tick_s ? CW'(0) : cnt_q + CW'(1);
        sd1_d      = bus.JOY_DATA;
        sd_d       = sd1_q;

        if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_d    = ST_LOAD;
                        load_cnt_d = LW'(0);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (load_cnt_q == LOAD_LAST) begin
                        state_d = ST_SHIFT_LO;
                        k_d     = KW'(0);
                    end else begin
                        load_cnt_d = load_cnt_q + LW'(1);
                    end
                end
                ST_SHIFT_LO: begin
                    raw_d[k_q] = sd_q;
                    state_d    = ST_SHIFT_HI;
                end
                ST_SHIFT_HI: begin
                    if (k_q == K_LAST) begin
                        state_d = ST_COMMIT;
                    end else begin
                        k_d     = k_q + KW'(1);
                        state_d = ST_SHIFT_LO;
                    end
                end
                ST_COMMIT: begin
                    joystick_d = decoded_s[N-1:0];
                    present_d  = decoded_s[N+PLAYERS-1:N];
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        // Strobes follow the state being entered so their edges land one clk after tick.
        joy_clk_d  = (state_d == ST_SHIFT_HI);
        joy_load_d = (state_d != ST_LOAD);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= CW'(0);
            k_q        <= KW'(0);
            load_cnt_q <= LW'(0);
            raw_q      <= {N{1'b0}};
            sd1_q      <= 1'b0;
            sd_q       <= 1'b0;
            joy_clk_q  <= 1'b0;
            joy_load_q <= 1'b1;
            joystick_q <= {N{1'b0}};
            present_q  <= {PLAYERS{1'b0}};
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            load_cnt_q <= load_cnt_d;
            raw_q      <= raw_d;
            sd1_q      <= sd1_d;
            sd_q       <= sd_d;
            joy_clk_q  <= joy_clk_d;
            joy_load_q <= joy_load_d;
            joystick_q <= joystick_d;
            present_q  <= present_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.JOY_CLK  = joy_clk_q;
    assign bus.JOY_LOAD = joy_load_q;
    assign bus.joystick = joystick_q;
    assign bus.present  = present_q;
    assign bus.valid    = valid_q;
endmodule

// File: tb/tb_joy_serial_reader.sv
// Directed bench: a 74HC165-like chain model feeds two reader instances
// (defaults, and a 4x12 non-inverting variant), both with CLK_DIV=4.
module tb_joy_serial_reader;
    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    always #5 clk = ~clk;

    joy_serial_reader_if #(.PLAYERS(2), .BITS(16)) ifa ();
    joy_serial_reader_if #(.PLAYERS(4), .BITS(12)) ifb ();

    joy_serial_reader #(.CLK_DIV(4)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .bus(ifa)
    );
    joy_serial_reader #(.PLAYERS(4), .BITS(12), .CLK_DIV(4), .INVERT(0)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .bus(ifb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Shift-register chain model: parallel load while JOY_LOAD low, advance on JOY_CLK rise.
    logic [31:0] wire_a = 32'h0;
    logic [47:0] wire_b = 48'h0;
    int   idx_a = 0;
    int   idx_b = 0;
    logic pclk_a = 1'b0;
    logic pclk_b = 1'b0;
    logic tog_en = 1'b0;
    logic tog_bit = 1'b0;

    always @(posedge clk) begin
        if (!ifa.JOY_LOAD) idx_a <= 0;
        else if (ifa.JOY_CLK && !pclk_a) idx_a <= idx_a + 1;
        pclk_a <= ifa.JOY_CLK;
        if (!ifb.JOY_LOAD) idx_b <= 0;
        else if (ifb.JOY_CLK && !pclk_b) idx_b <= idx_b + 1;
        pclk_b <= ifb.JOY_CLK;
    end

    assign ifa.JOY_DATA = tog_en ? tog_bit : ((idx_a < 32) ? wire_a[idx_a[4:0]] : 1'b1);
    assign ifb.JOY_DATA = (idx_b < 48) ? wire_b[idx_b[5:0]] : 1'b1;

    int vcnt_a = 0;
    always @(negedge clk) if (ifa.valid) vcnt_a <= vcnt_a + 1;

    task automatic wait_valid(input bit sel, input int limit, output int cycles, output int lo,
                              output int hi, output int rises, output bit ok);
        logic prev, ck, ld, v;
        ok = 1'b0; cycles = 0; lo = 0; hi = 0; rises = 0;
        prev = sel ? ifb.JOY_CLK : ifa.JOY_CLK;
        while (!ok && cycles < limit) begin
            @(negedge clk);
            cycles++;
            ck = sel ? ifb.JOY_CLK  : ifa.JOY_CLK;
            ld = sel ? ifb.JOY_LOAD : ifa.JOY_LOAD;
            v  = sel ? ifb.valid    : ifa.valid;
            if (!ld) lo++;
            if (ck) hi++;
            if (ck && !prev) rises++;
            prev = ck;
            if (v) ok = 1'b1;
        end
    endtask

    task automatic wait_rises_a(input int n, output bit ok);
        int   cnt;
        int   cyc;
        logic prev;
        cnt = 0; cyc = 0; prev = ifa.JOY_CLK;
        while (cnt < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (ifa.JOY_CLK && !prev) cnt++;
            prev = ifa.JOY_CLK;
        end
        ok = (cnt == n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, lo, hi, rises, n, v0, ld_seen, v_seen;
        bit  ok;
        ifa.enable = 1'b0;
        ifb.enable = 1'b1;

        // Reset held while the data line toggles.
        tog_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tog_bit = ~tog_bit;
        end
        check_eq("rst_joy_clk",  ifa.JOY_CLK,  1'b0);
        check_eq("rst_joy_load", ifa.JOY_LOAD, 1'b1);
        check_eq("rst_joystick", ifa.joystick, 32'h0);
        check_eq("rst_present",  ifa.present,  2'b00);
        check_eq("rst_valid_cnt", vcnt_a, 0);

        // Bit mapping with inverted wire levels.
        tog_en = 1'b0;
        wire_a = {16'h7FFF, 16'hFFFE};
        ifa.enable = 1'b1;
        @(negedge clk);
        rst_a_n = 1'b1;
        wait_valid(1'b0, 1000, cyc, lo, hi, rises, ok);
        check_eq("f1_valid_seen", ok, 1'b1);
        check_eq("f1_joystick", ifa.joystick, 32'h8000_0001);
        check_eq("f1_present",  ifa.present,  2'b11);

        // Strobe shape over one full steady-state frame.
        wait_valid(1'b0, 1000, cyc, lo, hi, rises, ok);
        check_eq("f2_valid_seen", ok, 1'b1);
        check_eq("f2_period",     cyc,   272);
        check_eq("f2_load_low",   lo,    8);
        check_eq("f2_clk_high",   hi,    128);
        check_eq("f2_clk_pulses", rises, 32);
        @(negedge clk);
        check_eq("valid_width", ifa.valid, 1'b0);

        // Presence: pad1 reads all-pressed, then released.
        wire_a = {16'h0000, 16'hFFFE};
        wait_valid(1'b0, 1000, cyc, lo, hi, rises, ok);
        check_eq("p1_valid_seen", ok, 1'b1);
        check_eq("p1_present",  ifa.present,  2'b01);
        check_eq("p1_joystick", ifa.joystick, 32'h0000_0001);
        wire_a = {16'hFFFF, 16'hFFFE};
        wait_valid(1'b0, 1000, cyc, lo, hi, rises, ok);
        check_eq("p2_valid_seen", ok, 1'b1);
        check_eq("p2_present",  ifa.present,  2'b11);
        check_eq("p2_joystick", ifa.joystick, 32'h0000_0001);

        // Enable dropped during SHIFT_HI of bit 10: frame completes, then parks.
        wire_a = {16'hFFFF, 16'h1234};
        wait_rises_a(11, ok);
        check_eq("en_rises_seen", ok, 1'b1);
        ifa.enable = 1'b0;
        v0 = vcnt_a;
        wait_valid(1'b0, 1000, cyc, lo, hi, rises, ok);
        check_eq("en_valid_seen", ok, 1'b1);
        check_eq("en_joystick", ifa.joystick, 32'h0000_EDCB);
        check_eq("en_present",  ifa.present,  2'b11);
        ld_seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!ifa.JOY_LOAD) ld_seen++;
        end
        check_eq("park_no_load", ld_seen, 0);
        check_eq("park_one_valid", vcnt_a - v0, 1);
        check_eq("park_hold", ifa.joystick, 32'h0000_EDCB);
        ifa.enable = 1'b1;
        n = 0;
        while (ifa.JOY_LOAD && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("load_restart_fast", (n >= 1 && n <= 4), 1'b1);

        // Reset asserted mid-shift: strobes return at once, no partial word published.
        wire_a = {16'h0F0F, 16'h5555};
        wait_rises_a(5, ok);
        check_eq("mid_rises_seen", ok, 1'b1);
        v_seen = vcnt_a;
        rst_a_n = 1'b0;
        #1;
        check_eq("mid_joy_clk",  ifa.JOY_CLK,  1'b0);
        check_eq("mid_joy_load", ifa.JOY_LOAD, 1'b1);
        check_eq("mid_valid",    ifa.valid,    1'b0);
        check_eq("mid_joystick", ifa.joystick, 32'h0);
        ifa.enable = 1'b0;
        repeat (10) @(negedge clk);
        rst_a_n = 1'b1;
        repeat (40) @(negedge clk);
        check_eq("post_joystick", ifa.joystick, 32'h0);
        check_eq("post_present",  ifa.present,  2'b00);
        check_eq("post_no_valid", vcnt_a, v_seen);

        // Parameter variant: 4 pads x 12 bits, non-inverting.
        wire_b = 48'h5A3C917E204B;
        @(negedge clk);
        rst_b_n = 1'b1;
        wait_valid(1'b1, 1000, cyc, lo, hi, rises, ok);
        check_eq("b1_valid_seen", ok, 1'b1);
        check_eq("b1_clk_pulses", rises, 48);
        check_eq("b1_joystick", ifb.joystick, 48'h5A3C917E204B);
        check_eq("b1_present",  ifb.present,  4'hF);
        wire_b = 48'hFFF123456789;
        wait_valid(1'b1, 1000, cyc, lo, hi, rises, ok);
        check_eq("b2_valid_seen", ok, 1'b1);
        check_eq("b2_joystick", ifb.joystick, 48'h000123456789);
        check_eq("b2_present",  ifb.present,  4'b0111);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/joy_serial_reader.md
# joy_serial_reader

Parametrised serial-shift joystick reader for 74HC165-style user-port adapters: generates the load and clock strobes, shifts in `PLAYERS` × `BITS` controller bits, and publishes one coherent word per frame. It is the generalised successor to the fixed two-pad, 16-bit DB15 reader. It adds:
- player count and bit width set by parameters;
- strobe rate set by a parameter;
- a data-line synchroniser;
- per-player presence detection;
- a frame-valid strobe.

It sits between the user-port pins and the core's joystick mux.

## Interface
Parameters:
- `PLAYERS`, 2 — number of daisy-chained pads, ≥1.
- `BITS`, 16 — bits per pad, ≥2.
- `CLK_DIV`, 250 — `clk` cycles per tick (one strobe half-period), ≥4.
- `LOAD_TICKS`, 2 — ticks `JOY_LOAD` is held low, ≥1.
- `INVERT`, 1 — 1: pad bits are active-low on the wire; output is inverted to active-high.

Ports:
- `clk` in 1 — single clock for the block, 40–50 MHz.
- `reset_n` in 1 — asynchronous, active-low reset.
- `enable` in 1 — start new frames while high.
- `JOY_DATA` in 1 — serial data from the shift-register chain; asynchronous.
- `JOY_CLK` out 1 — shift clock to the chain.
- `JOY_LOAD` out 1 — parallel-load strobe, active-low.
- `joystick` out `PLAYERS*BITS` — decoded word; pad p occupies `[p*BITS +: BITS]`.
- `present` out `PLAYERS` — per-pad presence flag.
- `valid` out 1 — one-`clk` pulse when `joystick`/`present` update.

## Operation
- Tick generator: a counter runs 0..`CLK_DIV`-1 and wraps. `tick` is asserted on the cycle the counter equals `CLK_DIV`-1. All state transitions happen only on `tick`.
- `JOY_DATA` passes through a 2-flop synchroniser (`sd`) before any use.
- FSM states, with outputs:
  - IDLE (`JOY_CLK`=0, `JOY_LOAD`=1): on tick, if `enable`=1 go to LOAD with load counter cleared; otherwise stay.
  - LOAD (`JOY_LOAD`=0): on each tick, increment the load counter. On the `LOAD_TICKS`-th tick go to SHIFT_LO with bit index k=0.
  - SHIFT_LO (`JOY_CLK`=0): on tick, `raw[k] <= sd`, then go to SHIFT_HI.
  - SHIFT_HI (`JOY_CLK`=1): on tick, if k = `PLAYERS*BITS`-1 go to COMMIT; otherwise k++ and go to SHIFT_LO.
  - COMMIT (`JOY_CLK`=0, `JOY_LOAD`=1): on tick, update the outputs, pulse `valid`, and go to IDLE.
- Bit order: the first bit sampled is `raw[0]` (pad 0, bit 0). The last bit sampled is `raw[PLAYERS*BITS-1]`.
- Decode per pad p, where w = `raw[p*BITS +: BITS]`:
  - d = `INVERT` ? ~w : w.
  - `present[p]` = 0 when d is all ones, meaning every input reads as pressed. This indicates a missing adapter or a data line stuck at the active level. Otherwise `present[p]` = 1.
  - `joystick[p*BITS +: BITS]` = `present[p]` ? d : 0.
- `enable` is examined only in IDLE. Deasserting it mid-frame lets the current frame finish and commit; the block then parks in IDLE.
- Outputs hold their last committed values between commits and while parked.
- Widths: k is `$clog2(PLAYERS*BITS)` bits; the load counter is `$clog2(LOAD_TICKS+1)` bits. Counters never overflow, because terminal compares precede each increment.

## Timing
- Reset (async, `reset_n`=0):
  - Outputs: `JOY_CLK`=0, `JOY_LOAD`=1, `joystick`=0, `present`=0, `valid`=0.
  - Internals: FSM in IDLE; tick counter, k, load counter, `raw` and synchroniser all cleared.
- Reset release: the first tick occurs `CLK_DIV` cycles later.
- Reset asserted mid-frame: immediate return to the reset state. No partial word is ever published.
- All outputs are registered. Strobe edges are coincident with the `clk` edge after `tick`.
- Frame length with `enable` held high: (2 + `LOAD_TICKS` + 2·`PLAYERS`·`BITS`) ticks. With defaults: 68 × 250 = 17000 clk.
- Sampling: data is taken at the end of the low half-period, one full tick after the preceding falling `JOY_CLK`. The synchroniser adds 2 clk; `CLK_DIV`≥4 guarantees the data is settled.
- `valid` is high for exactly one `clk`, coincident with the new `joystick`/`present` values.

## Test plan
- Reset: hold `reset_n`=0 and toggle `JOY_DATA` → all outputs stay at reset values. Assert `reset_n`=0 mid-SHIFT → `JOY_CLK`=0 and `JOY_LOAD`=1 within 1 clk, and `valid` never pulses.
- Strobe shape (defaults, `enable`=1, `CLK_DIV`=4 in the bench):
  - `JOY_LOAD` is low for 8 clk.
  - Then 32 `JOY_CLK` pulses, each high for 4 clk and low for 4 clk.
  - `valid` recurs every 68×4 clk.
- Bit mapping (`INVERT`=1): serial model sends pad0 = 16'hFFFE and pad1 = 16'h7FFF, each LSB first → `joystick`=32'h8000_0001, `present`=2'b11.
- Presence: pad1 wire word = 16'h0000 → `present`=2'b01 and `joystick[31:16]`=0. On the next frame with pad1 = 16'hFFFF → `present`=2'b11.
- Enable: drop `enable` during SHIFT_HI of bit 10 → that frame still commits with one `valid` pulse, then there are no further `JOY_LOAD` pulses. Reassert → LOAD begins on the next tick.
- Parameter sweep with `PLAYERS`=4, `BITS`=12, `INVERT`=0 and a random pattern → 48 clock pulses per frame and `joystick` equals the sent pattern.
